hsync_gen: RTL and testbench
============================

// Module: hsync_gen
// PURPOSE
//  Horizontal timing generator for the 640x480@60Hz VGA driver, run from the 50 MHz system clock.
//  Directly upstream of vsync: drives VGA_HSYNC to the connector and LINE_END, one tick per line.
//  vsync counts LINE_END ticks to build frame timing.
//  Also gives HDISPLAY and HPIXEL, a 128-column coarse pixel index, to the pixel/colour stage.
// PARAMETERS
//  H_SYNC   192   sync pulse length, clk cycles (96 px @ 25 MHz)
//  H_BP     96    back porch, clk cycles
//  H_DISP   1280  active video, clk cycles
//  H_FP     32    front porch, clk cycles
//  PIX_DIV  10    clk cycles per HPIXEL step; legal only if H_DISP/PIX_DIV <= 2**HPIX_W, H_DISP%PIX_DIV==0
//  HPIX_W   7     HPIXEL width
// PORTS
//  clk        in   1       system clock, 50 MHz
//  reset      in   1       synchronous, active-high
//  HPIXEL     out  HPIX_W  coarse column index during active video, 0 otherwise
//  HDISPLAY   out  1       1 during active video
//  VGA_HSYNC  out  1       horizontal sync to connector, active-low
//  LINE_END   out  1       one-cycle pulse on the last cycle of each line
// BEHAVIOUR
//  - One clock (clk). reset is synchronous and active-high, sampled on the rising edge of clk.
//  - FSM states: SYNC -> BP -> DISP -> FP -> SYNC. The FSM has a per-state down/up counter.
//  - Each state lasts exactly H_SYNC, H_BP, H_DISP or H_FP cycles.
//  - Line period L = H_SYNC+H_BP+H_DISP+H_FP = 1600 cycles (32 us).
//  - HPIXEL comes from a divide counter (0..PIX_DIV-1) plus a column counter.
//  - No multiplier or divider is used for HPIXEL.
//  - All outputs are registered and show the FSM position of the previous cycle (1-cycle latency).
//  - Reset (edge with reset=1):
//    - State = SYNC, counters = 0.
//    - Outputs: VGA_HSYNC=1, HDISPLAY=0, HPIXEL=0, LINE_END=0.
//  - Position p: at the k-th rising edge after reset deasserts (k>=1), outputs show p=(k-1) mod L.
//  - Output decode by p:
//    - p 0..191: VGA_HSYNC=0. All other p: VGA_HSYNC=1.
//    - p 192..287: back porch, all outputs idle.
//    - p 288..1567: HDISPLAY=1, HPIXEL=floor((p-288)/PIX_DIV), giving 0..127.
//    - p 1568..1599: front porch, HDISPLAY=0, HPIXEL=0.
//    - p 1599 (=L-1): LINE_END=1. LINE_END=0 otherwise.
//  - Wrap-around: after p=L-1 the next position is p=0 (SYNC). There is no idle gap between lines.
//  - HPIXEL steps at the column boundary and never wraps past 127 inside DISP.
//  - HPIXEL returns to 0 on the same edge that HDISPLAY falls.
//  - Reset mid-line, any state: next edge forces reset values and aborts the line.
//    - No LINE_END is emitted for the aborted line.
//    - The sequence restarts at p=0, as for power-up.
//  - Reset held N cycles: outputs stay at reset values for all N edges.
//  - Reset and the p=L-1 position on the same edge: reset wins, so LINE_END=0.
// TESTING
//  1. Reset pulse of 20 ns, then free run:
//     - During reset: VGA_HSYNC=1, HDISPLAY=0, HPIXEL=0, LINE_END=0.
//     - VGA_HSYNC falls at edge 1, rises at edge 193 (3840 ns low).
//  2. Same run, active video:
//     - HDISPLAY rises at edge 289 with HPIXEL=0. HPIXEL increments every 10 edges.
//     - HPIXEL=127 on edges 1559..1568. Edge 1569: HDISPLAY=0, HPIXEL=0.
//  3. Free run, 525 lines:
//     - LINE_END is a 1-cycle pulse at edges 1600, 3200, ... 840000.
//     - Every VGA_HSYNC period = 1600 cycles exactly.
//     - Never two consecutive LINE_END cycles.
//  4. Reset asserted for 1 cycle while HPIXEL=64:
//     - Reset values on that edge, and no LINE_END for the aborted line.
//     - Then an identical sequence to scenario 1 (VGA_HSYNC low at edge 1).
//  5. Reset asserted at p=1599 and held 5 cycles:
//     - LINE_END stays 0 and all outputs hold reset values for 5 edges.
//     - Restart at p=0 afterwards.
//  6. Override H_SYNC=4, H_BP=2, H_DISP=8, H_FP=2, PIX_DIV=2:
//     - Period is 16 cycles. VGA_HSYNC low at p 0..3, HDISPLAY at p 6..13.
//     - HPIXEL runs 0,0,1,1,2,2,3,3. LINE_END at p=15.

Source files
------------

// File: rtl/hsync_gen.sv
// Horizontal timing generator for the 640x480@60Hz VGA path at 50 MHz.
// Walks SYNC -> BP -> DISP -> FP each line and emits registered sync, display, column and line-end.
module hsync_gen #(
    parameter int unsigned H_SYNC  = 192,
    parameter int unsigned H_BP    = 96,
    parameter int unsigned H_DISP  = 1280,
    parameter int unsigned H_FP    = 32,
    parameter int unsigned PIX_DIV = 10,
    parameter int unsigned HPIX_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    output logic [HPIX_W-1:0] HPIXEL,
    output logic              HDISPLAY,
    output logic              VGA_HSYNC,
    output logic              LINE_END
);

    localparam int unsigned MAX_A   = (H_SYNC > H_BP) ? H_SYNC : H_BP;
    localparam int unsigned MAX_B   = (H_DISP > H_FP) ? H_DISP : H_FP;
    localparam int unsigned MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned DIV_W   = $clog2(PIX_DIV + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(H_SYNC - 1);
    localparam logic [CNT_W-1:0] BP_LAST   = CNT_W'(H_BP - 1);
    localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(H_DISP - 1);
    localparam logic [CNT_W-1:0] FP_LAST   = CNT_W'(H_FP - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PIX_DIV - 1);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_BP   = 2'd1,
        ST_DISP = 2'd2,
        ST_FP   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [HPIX_W-1:0] col_q, col_d;
    logic              last_c;

    logic              hsync_q, hsync_d;
    logic              disp_q, disp_d;
    logic [HPIX_W-1:0] hpix_q, hpix_d;
    logic              line_end_q, line_end_d;

    // State and position registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            div_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            col_q   <= col_d;
        end
    end

    // Next state, per-state counter and column divider; column state is cleared outside DISP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        div_d   = '0;
        col_d   = '0;
        last_c  = 1'b0;

        case (state_q)
            ST_SYNC: last_c = (cnt_q == SYNC_LAST);
            ST_BP:   last_c = (cnt_q == BP_LAST);
            ST_DISP: last_c = (cnt_q == DISP_LAST);
            ST_FP:   last_c = (cnt_q == FP_LAST);
            default: last_c = 1'b1;
        endcase

        if (last_c) begin
            cnt_d = '0;
            case (state_q)
                ST_SYNC: state_d = ST_BP;
                ST_BP:   state_d = ST_DISP;
                ST_DISP: state_d = ST_FP;
                default: state_d = ST_SYNC;
            endcase
        end

        if ((state_q == ST_DISP) && !last_c) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                col_d = col_q + HPIX_W'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
                col_d = col_q;
            end
        end
    end

    // Output decode of the current position, registered below
    always_comb begin
        hsync_d    = 1'b1;
        disp_d     = 1'b0;
        hpix_d     = '0;
        line_end_d = 1'b0;

        case (state_q)
            ST_SYNC: hsync_d = 1'b0;
            ST_DISP: begin
                disp_d = 1'b1;
                hpix_d = col_q;
            end
            ST_FP:   line_end_d = (cnt_q == FP_LAST);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q    <= 1'b1;
            disp_q     <= 1'b0;
            hpix_q     <= '0;
            line_end_q <= 1'b0;
        end else begin
            hsync_q    <= hsync_d;
            disp_q     <= disp_d;
            hpix_q     <= hpix_d;
            line_end_q <= line_end_d;
        end
    end

    assign VGA_HSYNC = hsync_q;
    assign HDISPLAY  = disp_q;
    assign HPIXEL    = hpix_q;
    assign LINE_END  = line_end_q;

endmodule

// File: tb/tb_hsync_gen.sv
// Directed bench for hsync_gen: default VGA timing and a small override instance share clock and reset.
module tb_hsync_gen;

    localparam int unsigned LA = 1600;
    localparam int unsigned LB = 16;

    logic       clk;
    logic       reset;
    logic [6:0] hpix_a, hpix_b;
    logic       disp_a, hs_a, le_a;
    logic       disp_b, hs_b, le_b;

    int unsigned total;
    int unsigned bad;
    int unsigned pa, pb, k;
    int unsigned last_fall, le_cnt;
    logic        prev_hs, prev_le;

    // Hand-derived expectations for the override instance, indexed by position 0..15
    logic        b_hs   [16] = '{0,0,0,0,1,1,1,1,1,1,1,1,1,1,1,1};
    logic        b_disp [16] = '{0,0,0,0,0,0,1,1,1,1,1,1,1,1,0,0};
    int unsigned b_pix  [16] = '{0,0,0,0,0,0,0,0,1,1,2,2,3,3,0,0};
    logic        b_le   [16] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1};

    hsync_gen u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .HPIXEL    (hpix_a),
        .HDISPLAY  (disp_a),
        .VGA_HSYNC (hs_a),
        .LINE_END  (le_a)
    );

    hsync_gen #(
        .H_SYNC  (4),
        .H_BP    (2),
        .H_DISP  (8),
        .H_FP    (2),
        .PIX_DIV (2),
        .HPIX_W  (7)
    ) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .HPIXEL    (hpix_b),
        .HDISPLAY  (disp_b),
        .VGA_HSYNC (hs_b),
        .LINE_END  (le_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (edge %0d)", tag, got, exp, k);
        end
    endtask

    task automatic model(input int unsigned p, input int unsigned hs, input int unsigned bp,
                         input int unsigned hd, input int unsigned fp, input int unsigned dv,
                         output logic e_hs, output logic e_disp,
                         output int unsigned e_pix, output logic e_le);
        e_hs   = (p >= hs);
        e_disp = (p >= hs + bp) && (p < hs + bp + hd);
        e_pix  = e_disp ? (p - hs - bp) / dv : 0;
        e_le   = (p == hs + bp + hd + fp - 1);
    endtask

    // One clock edge with the given reset level, then every output of both instances is checked
    task automatic step(input logic rst);
        logic        ehs, edisp, ele;
        int unsigned epix;
        reset = rst;
        @(posedge clk);
        @(negedge clk);
        if (rst) begin
            k = 0;
            check("a_rst_hsync", hs_a, 1);
            check("a_rst_hdisplay", disp_a, 0);
            check("a_rst_hpixel", hpix_a, 0);
            check("a_rst_line_end", le_a, 0);
            check("b_rst_hsync", hs_b, 1);
            check("b_rst_line_end", le_b, 0);
            pa = 0;
            pb = 0;
            last_fall = 0;
        end else begin
            k++;
            model(pa, 192, 96, 1280, 32, 10, ehs, edisp, epix, ele);
            check("a_hsync", hs_a, ehs);
            check("a_hdisplay", disp_a, edisp);
            check("a_hpixel", hpix_a, epix);
            check("a_line_end", le_a, ele);
            model(pb, 4, 2, 8, 2, 2, ehs, edisp, epix, ele);
            check("b_hsync", hs_b, ehs);
            check("b_hdisplay", disp_b, edisp);
            check("b_hpixel", hpix_b, epix);
            check("b_line_end", le_b, ele);
            pa = (pa + 1) % LA;
            pb = (pb + 1) % LB;
            if (prev_hs && !hs_a) begin
                if (last_fall != 0)
                    check("a_hsync_period", k - last_fall, LA);
                last_fall = k;
            end
        end
        check("a_le_consecutive", le_a & prev_le, 0);
        if (le_a)
            le_cnt++;
        prev_hs = hs_a;
        prev_le = le_a;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        pa        = 0;
        pb        = 0;
        k         = 0;
        last_fall = 0;
        le_cnt    = 0;
        prev_hs   = 1'b1;
        prev_le   = 1'b0;
        reset     = 1'b1;

        // Reset for one edge, then the first line with hand-computed landmarks
        step(1'b1);
        le_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            step(1'b0);
            case (k)
                1:    check("s1_hsync_fall", hs_a, 0);
                192:  check("s1_hsync_last_low", hs_a, 0);
                193:  check("s1_hsync_rise", hs_a, 1);
                288:  check("s2_hdisplay_pre", disp_a, 0);
                289: begin
                    check("s2_hdisplay_rise", disp_a, 1);
                    check("s2_hpixel_first", hpix_a, 0);
                end
                298:  check("s2_hpixel_hold", hpix_a, 0);
                299:  check("s2_hpixel_step", hpix_a, 1);
                1558: check("s2_hpixel_126", hpix_a, 126);
                1559: check("s2_hpixel_127", hpix_a, 127);
                1568: begin
                    check("s2_hpixel_last", hpix_a, 127);
                    check("s2_hdisplay_last", disp_a, 1);
                end
                1569: begin
                    check("s2_hdisplay_fall", disp_a, 0);
                    check("s2_hpixel_zero", hpix_a, 0);
                end
                1599: check("s3_line_end_pre", le_a, 0);
                1600: check("s3_line_end", le_a, 1);
                default: ;
            endcase
            if (k >= 1 && k <= 16) begin
                check("s6_hsync", hs_b, b_hs[k-1]);
                check("s6_hdisplay", disp_b, b_disp[k-1]);
                check("s6_hpixel", hpix_b, b_pix[k-1]);
                check("s6_line_end", le_b, b_le[k-1]);
            end
        end

        // Free run for 19 more lines
        for (int i = 0; i < 19 * 1600; i++)
            step(1'b0);
        check("s3_line_end_count", le_cnt, 20);

        // One-cycle reset while HPIXEL=64
        for (int i = 0; i < 1600 && pa != 931; i++)
            step(1'b0);
        check("s4_hpixel_64", hpix_a, 64);
        le_cnt = 0;
        step(1'b1);
        step(1'b0);
        check("s4_restart_hsync", hs_a, 0);
        check("s4_restart_edge", k, 1);
        for (int i = 0; i < 1599; i++)
            step(1'b0);
        check("s4_line_end_count", le_cnt, 1);

        // Reset landing on the last position of a line and held five edges
        for (int i = 0; i < 1600 && pa != 1599; i++)
            step(1'b0);
        check("s5_le_before", le_a, 0);
        le_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            check("s5_le_held", le_a, 0);
            check("s5_hsync_held", hs_a, 1);
        end
        check("s5_le_count", le_cnt, 0);
        step(1'b0);
        check("s5_restart_hsync", hs_a, 0);
        check("s5_restart_le", le_a, 0);
        for (int i = 0; i < 40; i++)
            step(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
